// File: rtl/dmem_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : dmem_arb_pkg
// Brief    : Shared types for the data-memory port arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dmem_arb_pkg;

    localparam int DM_ADDR_W = 9;
    localparam int DM_DATA_W = 32;
    localparam int STARVE_W  = 4;

    typedef enum logic [0:0] {
        S_CORE = 1'b0,
        S_DBG  = 1'b1
    } arb_state_t;

    // Field widths are fixed here; the arbiter's width parameters must match them.
    typedef struct packed {
        logic                 rd;
        logic                 wr;
        logic [DM_ADDR_W-1:0] addr;
        logic [DM_DATA_W-1:0] wdata;
        logic [2:0]           funct3;
    } dmem_req_t;

endpackage

`default_nettype wire

// File: rtl/dmem_req_mux.sv
//------------------------------------------------------------------------------
// Module   : dmem_req_mux
// Brief    : 2:1 selection of a data-memory request by debug grant.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_req_mux
    import dmem_arb_pkg::*;
(
    input  logic      sel_dbg_i,
    input  dmem_req_t core_req_i,
    input  dmem_req_t dbg_req_i,
    output dmem_req_t mem_req_o
);

    assign mem_req_o = sel_dbg_i ? dbg_req_i : core_req_i;

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : dmem_arbiter
// Brief    : Shares the data-memory port between the core MEM stage and a
//            debug/loader master, with starvation-bounded debug preemption.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DM_ADDRESS = DM_ADDR_W,
    parameter int DATA_W     = DM_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  core_rd,
    input  logic                  core_wr,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_funct3,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_stall,

    input  logic                  dbg_valid,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    input  logic [2:0]            dbg_funct3,
    output logic                  dbg_ready,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,

    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam logic [STARVE_W-1:0] c_starve_max = STARVE_MAX[STARVE_W-1:0];

    arb_state_t          state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic                dbg_rvalid_q, dbg_rvalid_d;

    logic      w_core_req;
    logic      w_grant;
    dmem_req_t w_core_req_s;
    dmem_req_t w_dbg_req_s;
    dmem_req_t w_mem_req_s;

    assign w_core_req = core_rd | core_wr;
    assign w_grant    = (state_q == S_DBG);

    assign w_core_req_s = '{rd: core_rd, wr: core_wr, addr: core_addr,
                            wdata: core_wdata, funct3: core_funct3};
    assign w_dbg_req_s  = '{rd: ~dbg_we, wr: dbg_we, addr: dbg_addr,
                            wdata: dbg_wdata, funct3: dbg_funct3};

    dmem_req_mux u_req_mux (
        .sel_dbg_i  (w_grant),
        .core_req_i (w_core_req_s),
        .dbg_req_i  (w_dbg_req_s),
        .mem_req_o  (w_mem_req_s)
    );

    // A debug slot caught by reset is abandoned: no write, no handshake.
    assign mem_rd     = w_mem_req_s.rd;
    assign mem_wr     = w_mem_req_s.wr & ~reset;
    assign mem_addr   = w_mem_req_s.addr;
    assign mem_wdata  = w_mem_req_s.wdata;
    assign mem_funct3 = w_mem_req_s.funct3;

    assign core_rdata = w_grant ? '0 : mem_rdata;
    assign core_stall = w_grant & w_core_req;
    assign dbg_ready  = w_grant & ~reset;
    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            S_CORE: begin
                if (dbg_valid && (!w_core_req || starve_q == c_starve_max)) begin
                    state_d  = S_DBG;
                    starve_d = '0;
                end else if (!dbg_valid) begin
                    starve_d = '0;
                end else if (w_core_req && starve_q != c_starve_max) begin
                    starve_d = starve_q + 1'b1;
                end
            end
            S_DBG: begin
                // Single-cycle slot; returning to the core bounds debug bandwidth to 1/2.
                state_d  = S_CORE;
                starve_d = '0;
            end
            default: begin
                state_d  = S_CORE;
                starve_d = '0;
            end
        endcase
    end

    always_comb begin
        dbg_rvalid_d = w_grant & ~dbg_we;
        dbg_rdata_d  = (w_grant && !dbg_we) ? mem_rdata : dbg_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_CORE;
            starve_q     <= '0;
            dbg_rdata_q  <= '0;
            dbg_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            dbg_rdata_q  <= dbg_rdata_d;
            dbg_rvalid_q <= dbg_rvalid_d;
        end
    end

    a_core_rd_wr_exclusive : assert property (@(posedge clk) disable iff (reset)
        !(core_rd && core_wr));

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter with a behavioural model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_rd, core_wr;
    logic [8:0]  core_addr;
    logic [31:0] core_wdata;
    logic [2:0]  core_funct3;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        dbg_valid, dbg_we;
    logic [8:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic [2:0]  dbg_funct3;
    logic        dbg_ready, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_rd, mem_wr;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_funct3(core_funct3),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_funct3(dbg_funct3),
        .dbg_ready(dbg_ready), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
    );

    // Word-organised data memory: combinational read, write at the clock edge.
    logic [31:0] env_mem [128] = '{default: 32'h0};
    assign mem_rdata = env_mem[mem_addr[8:2]];
    always @(posedge clk) if (mem_wr) env_mem[mem_addr[8:2]] <= mem_wdata;

    int checks = 0;
    int failures = 0;

    // Reference model: debug owns a slot right after it was pending with the
    // core idle or after STARVE_MAX blocked cycles; slots never run back to back.
    logic [31:0] ref_mem [128];
    bit          m_slot;
    int          m_wait;
    bit          m_rv;
    logic [31:0] m_rdata;

    logic        last_ready, last_stall;
    logic [31:0] last_core_rdata;
    int          stall_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit creq, take;
        creq = core_rd | core_wr;
        @(negedge clk);
        if (reset) begin
            chk("reset_mem_wr", mem_wr, 0);
            chk("reset_dbg_ready", dbg_ready, 0);
        end else begin
            chk("dbg_ready", dbg_ready, m_slot);
            chk("core_stall", core_stall, m_slot & creq);
            chk("dbg_rvalid", dbg_rvalid, m_rv);
            chk("dbg_rdata", dbg_rdata, m_rdata);
            chk("mem_rd", mem_rd, m_slot ? !dbg_we : core_rd);
            chk("mem_wr", mem_wr, m_slot ? dbg_we : core_wr);
            chk("mem_addr", mem_addr, m_slot ? dbg_addr : core_addr);
            chk("mem_funct3", mem_funct3, m_slot ? dbg_funct3 : core_funct3);
            if (m_slot) chk("core_rdata_slot", core_rdata, 0);
            else if (core_rd) chk("core_rdata", core_rdata, ref_mem[core_addr[8:2]]);
            if (core_stall) stall_cnt++;
        end
        last_ready      = dbg_ready;
        last_stall      = core_stall;
        last_core_rdata = core_rdata;
        if (reset) begin
            m_slot = 0; m_wait = 0; m_rv = 0; m_rdata = 0;
        end else if (m_slot) begin
            m_rv = !dbg_we;
            if (dbg_we) ref_mem[dbg_addr[8:2]] = dbg_wdata;
            else m_rdata = ref_mem[dbg_addr[8:2]];
            m_slot = 0; m_wait = 0;
        end else begin
            m_rv = 0;
            if (core_wr) ref_mem[core_addr[8:2]] = core_wdata;
            take = dbg_valid && (!creq || m_wait == STARVE_MAX);
            if (!dbg_valid || take) m_wait = 0;
            else if (m_wait < STARVE_MAX) m_wait++;
            m_slot = take;
        end
        @(posedge clk); #1;
    endtask

    task automatic dbg_txn(input logic we, input logic [8:0] addr, input logic [31:0] data,
                           output int lat);
        dbg_valid = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = data; dbg_funct3 = 3'b010;
        lat = 0;
        do begin cycle(); lat++; end while (!last_ready && lat < 20);
        chk("dbg_txn_ready", last_ready, 1);
        dbg_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, s0, age, idx[4], k;
        for (int i = 0; i < 128; i++) ref_mem[i] = 32'h0;
        m_slot = 0; m_wait = 0; m_rv = 0; m_rdata = 0;
        reset = 1; core_rd = 0; core_wr = 0; core_addr = 0; core_wdata = 0; core_funct3 = 0;
        dbg_valid = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_funct3 = 0;
        @(posedge clk); #1;
        cycle(); cycle();
        reset = 0;
        chk("reset_rvalid", dbg_rvalid, 0);
        chk("reset_rdata", dbg_rdata, 0);
        cycle();
        chk("reset_ready", last_ready, 0);
        chk("reset_stall", last_stall, 0);

        // Preload 0xDEADBEEF at 0x010, then a plain core read
        dbg_txn(1, 9'h010, 32'hDEADBEEF, lat);
        core_rd = 1; core_addr = 9'h010;
        cycle();
        chk("core_read_deadbeef", last_core_rdata, 32'hDEADBEEF);
        chk("core_read_no_stall", last_stall, 0);
        chk("core_read_no_ready", last_ready, 0);
        core_rd = 0;

        // Debug write with the core idle
        dbg_txn(1, 9'h020, 32'h12345678, lat);
        chk("dbg_wr_idle_latency", lat - 1, 1);
        core_rd = 1; core_addr = 9'h020;
        cycle();
        chk("core_read_dbg_written", last_core_rdata, 32'h12345678);
        core_rd = 0;

        // Debug read: rvalid pulses after the slot, data then held
        dbg_txn(0, 9'h020, 32'h0, lat);
        chk("dbg_rd_rvalid", dbg_rvalid, 1);
        chk("dbg_rd_rdata", dbg_rdata, 32'h12345678);
        cycle();
        chk("dbg_rvalid_pulse_end", dbg_rvalid, 0);
        chk("dbg_rdata_held", dbg_rdata, 32'h12345678);

        // Starvation under continuous core reads
        core_rd = 1; core_addr = 9'h010;
        s0 = stall_cnt;
        dbg_txn(0, 9'h020, 32'h0, lat);
        chk("starve_latency", lat - 1, STARVE_MAX + 1);
        chk("starve_stall_at_slot", last_stall, 1);
        cycle();
        chk("stalled_read_serviced", last_core_rdata, 32'hDEADBEEF);
        chk("stalled_read_no_stall", last_stall, 0);
        chk("starve_stall_count", stall_cnt - s0, 1);
        core_rd = 0;

        // Four queued debug writes with the core idle
        k = 0;
        dbg_valid = 1; dbg_we = 1; dbg_funct3 = 3'b010;
        dbg_addr = 9'h040; dbg_wdata = 32'hA0000000;
        for (int c = 0; c < 20 && k < 4; c++) begin
            cycle();
            if (last_ready) begin
                idx[k] = c; k++;
                dbg_addr = 9'(9'h040 + 4 * k); dbg_wdata = 32'hA0000000 + k;
            end
        end
        dbg_valid = 0;
        chk("b2b_count", k, 4);
        chk("b2b_first", idx[0], 1);
        for (int i = 1; i < 4; i++) chk("b2b_gap", idx[i] - idx[i-1], 2);
        for (int i = 0; i < 4; i++) begin
            core_rd = 1; core_addr = 9'(9'h040 + 4 * i);
            cycle();
            chk("b2b_word", last_core_rdata, 32'hA0000000 + i);
        end
        core_rd = 0;

        // Reset arriving during a debug-write slot
        dbg_valid = 1; dbg_we = 1; dbg_addr = 9'h030; dbg_wdata = 32'hCAFEF00D;
        cycle();
        reset = 1;
        cycle();
        reset = 0; dbg_valid = 0;
        chk("rst_slot_rvalid", dbg_rvalid, 0);
        core_rd = 1; core_addr = 9'h030;
        cycle();
        chk("rst_slot_no_write", last_core_rdata, 0);
        chk("rst_slot_core_owns", last_stall, 0);
        chk("rst_slot_env_mem", env_mem[12], 0);
        core_rd = 0;
        dbg_txn(1, 9'h034, 32'h5A5A5A5A, lat);
        chk("post_reset_idle_latency", lat - 1, 1);

        // Randomised traffic
        age = 0;
        for (int n = 0; n < 600; n++) begin
            if (!last_stall) begin
                case ($urandom_range(0, 3))
                    0:       begin core_rd = 0; core_wr = 0; end
                    2:       begin core_rd = 0; core_wr = 1; end
                    default: begin core_rd = 1; core_wr = 0; end
                endcase
                core_addr   = {7'($urandom_range(0, 127)), 2'b00};
                core_wdata  = $urandom;
                core_funct3 = 3'($urandom_range(0, 7));
            end
            if (!dbg_valid && $urandom_range(0, 2) == 0) begin
                dbg_valid = 1; dbg_we = 1'($urandom_range(0, 1));
                dbg_addr = {7'($urandom_range(0, 127)), 2'b00};
                dbg_wdata = $urandom; dbg_funct3 = 3'($urandom_range(0, 7));
                age = 0;
            end
            cycle();
            if (dbg_valid) begin
                age++;
                if (last_ready) begin
                    chk("rand_dbg_latency_ok", age <= STARVE_MAX + 2, 1);
                    dbg_valid = 0;
                end else if (age > STARVE_MAX + 2) begin
                    chk("rand_dbg_timeout", age, STARVE_MAX + 2);
                    dbg_valid = 0;
                end
            end
        end
        core_rd = 0; core_wr = 0; dbg_valid = 0;
        cycle(); cycle();
        for (int i = 0; i < 128; i++) chk("final_mem", env_mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
